// File: rtl/data_mem_ctrl_pkg.sv
// ============================================================================
// Module : data_mem_ctrl_pkg
// Brief  : Shared FSM state encoding, byte-enable constant and lane helpers
//          for the data memory load/store controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package data_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } dmc_state_e;

  localparam logic [3:0] BE_WORD = 4'hF;

  function automatic logic [3:0] byte_be(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  // Zero-extended byte selected from a little-endian word.
  function automatic logic [31:0] byte_lane(input logic [31:0] data, input logic [1:0] lane);
    logic [31:0] r;
    r = '0;
    case (lane)
      2'd0:    r[7:0] = data[7:0];
      2'd1:    r[7:0] = data[15:8];
      2'd2:    r[7:0] = data[23:16];
      default: r[7:0] = data[31:24];
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_ctrl_bus_timer.sv
// ============================================================================
// Module : bus_timer
// Brief  : Clear/enable cycle counter flagging the last allowed bus wait cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int WIDTH = $clog2(TIMEOUT_CYCLES);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset || i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ============================================================================
// Module : data_mem_ctrl
// Brief  : Load/store unit with valid/ack bus, core stall, sticky misalign and
//          timeout flags. Byte access (LDRB/STRB) enabled by DMC_BYTE_ACCESS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
`ifdef DMC_BYTE_ACCESS_EN
  input  logic              byte_acc,
`endif
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic              err_align,
  output logic              err_timeout
);

  dmc_state_e        r_state;
  dmc_state_e        w_state_nxt;
  logic              w_req;
  logic              w_misalign;
  logic              w_expired;
  logic              w_byte;
  logic [31:0]       w_load_data;
  logic [ADDR_W-3:0] r_waddr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [3:0]        r_be;
  logic              r_we;
  logic              r_err_align;
  logic              r_err_timeout;

`ifdef DMC_BYTE_ACCESS_EN
  logic       r_byte;
  logic [1:0] r_lane;
  assign w_byte      = byte_acc;
  assign w_load_data = r_byte ? byte_lane(bus_rdata, r_lane) : bus_rdata;
`else
  assign w_byte      = 1'b0;
  assign w_load_data = bus_rdata;
`endif

  assign w_req      = mem_rd | mem_wr;
  assign w_misalign = !w_byte && (addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Requests are ignored in DONE so the retiring instruction cannot re-issue.
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = w_req;
        if (w_req) w_state_nxt = w_misalign ? S_DONE : S_BUS;
      end
      S_BUS: begin
        stall = 1'b1;
        if (bus_ack || w_expired) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_waddr       <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_be          <= '0;
      r_we          <= 1'b0;
      r_err_align   <= 1'b0;
      r_err_timeout <= 1'b0;
`ifdef DMC_BYTE_ACCESS_EN
      r_byte        <= 1'b0;
      r_lane        <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_waddr <= addr[ADDR_W-1:2];
            r_we    <= mem_wr;
`ifdef DMC_BYTE_ACCESS_EN
            r_byte  <= byte_acc;
            r_lane  <= addr[1:0];
            r_be    <= byte_acc ? byte_be(addr[1:0]) : BE_WORD;
            r_wdata <= byte_acc ? {4{wdata[7:0]}} : wdata;
`else
            r_be    <= BE_WORD;
            r_wdata <= wdata;
`endif
            if (w_misalign) begin
              r_err_align <= 1'b1;
              r_rdata     <= '0;
            end
          end
        end
        S_BUS: begin
          // An ack on the final allowed cycle takes priority over the timeout.
          if (bus_ack) begin
            if (!r_we) r_rdata <= w_load_data;
          end else if (w_expired) begin
            r_err_timeout <= 1'b1;
            r_rdata       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  bus_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_bus_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (r_state != S_BUS),
    .i_en     (r_state == S_BUS),
    .o_expired(w_expired)
  );

  assign rdata       = r_rdata;
  assign bus_req     = (r_state == S_BUS);
  assign bus_we      = r_we;
  assign bus_addr    = {r_waddr, 2'b00};
  assign bus_wdata   = r_wdata;
  assign bus_be      = r_be;
  assign err_align   = r_err_align;
  assign err_timeout = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ============================================================================
// Module : tb_data_mem_ctrl
// Brief  : Self-checking bench for data_mem_ctrl with directed and random
//          load/store transactions against a transaction-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_mem_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        byte_acc = 1'b0;
  logic [31:0] rdata;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        err_align;
  logic        err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Architectural model state
  logic [31:0] m_rdata;
  logic        m_err_align;
  logic        m_err_timeout;

  data_mem_ctrl #(
    .ADDR_W(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .addr       (addr),
    .wdata      (wdata),
`ifdef DMC_BYTE_ACCESS_EN
    .byte_acc   (byte_acc),
`endif
    .rdata      (rdata),
    .stall      (stall),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .err_align  (err_align),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rdata"}, rdata, m_rdata);
    check({tag, "_err_align"}, {31'd0, err_align}, {31'd0, m_err_align});
    check({tag, "_err_timeout"}, {31'd0, err_timeout}, {31'd0, m_err_timeout});
  endtask

  // Two reset edges with requests low; everything must read back as zero.
  task automatic do_reset();
    reset  = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    bus_ack = 1'b0;
    step();
    check("rst1_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst1_stall", {31'd0, stall}, 32'd0);
    step();
    m_rdata = '0;
    m_err_align = 1'b0;
    m_err_timeout = 1'b0;
    check("rst_outs", {bus_req, bus_we, bus_be, stall}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check_model("rst");
    reset = 1'b1;
  endtask

  // ack_at: BUS cycle (1-based) on which ack is returned; 0 = never.
  task automatic access(input bit wr, input bit rd, input bit byt, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_at, input logic [31:0] rd_data);
    int          n_stall;
    int          n_bus;
    int          exp_bus;
    bit          done;
    bit          eff_byte;
    bit          mis;
    bit          acked;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    n_stall = 0;
    n_bus   = 0;
    done    = 1'b0;
`ifdef DMC_BYTE_ACCESS_EN
    eff_byte = byt;
`else
    eff_byte = 1'b0;
`endif
    mis = !eff_byte && (a[1:0] != 2'b00);
    ebe = eff_byte ? (4'b0001 << a[1:0]) : 4'hF;
    ewd = eff_byte ? {4{wd[7:0]}} : wd;
    acked = (ack_at >= 1) && (ack_at <= TO);
    exp_bus = mis ? 0 : (acked ? ack_at : TO);

    mem_wr = wr;
    mem_rd = rd;
    addr = a;
    wdata = wd;
    byte_acc = byt;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (!stall) begin
        done = 1'b1;
        break;
      end
      n_stall++;
      if (bus_req) begin
        n_bus++;
        check("bus_addr", bus_addr, {a[31:2], 2'b00});
        check("bus_ctl", {27'd0, bus_we, bus_be}, {27'd0, wr, ebe});
        check("bus_wdata", bus_wdata, ewd);
        if (n_bus == ack_at) begin
          bus_ack = 1'b1;
          bus_rdata = rd_data;
        end else begin
          bus_ack = 1'b0;
          bus_rdata = $urandom;
        end
      end else begin
        bus_ack = 1'b0;
      end
      step();
    end
    bus_ack = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    if (!done) check("watchdog_retire", 32'd0, 32'd1);

    if (mis) begin
      m_err_align = 1'b1;
      m_rdata = '0;
    end else if (!acked) begin
      m_err_timeout = 1'b1;
      m_rdata = '0;
    end else if (!wr) begin
      m_rdata = eff_byte ? ((rd_data >> (8 * a[1:0])) & 32'hFF) : rd_data;
    end

    check("stall_cycles", n_stall, exp_bus + 1);
    check("bus_cycles", n_bus, exp_bus);
    check("done_bus_req", {31'd0, bus_req}, 32'd0);
    check_model("done");
    step();
    check("idle_stall", {31'd0, stall}, 32'd0);
  endtask

  // Idle cycles with stray acks that must be ignored.
  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      bus_ack = 1'($urandom);
      bus_rdata = $urandom;
      step();
      check("noise_outs", {30'd0, stall, bus_req}, 32'd0);
      check("noise_rdata", rdata, m_rdata);
    end
    bus_ack = 1'b0;
  endtask

  initial begin
    int kind;
    int sel;
    int ack_at;
    logic [31:0] a;
    m_rdata = '0;
    m_err_align = 1'b0;
    m_err_timeout = 1'b0;
    step();
    do_reset();

    // misaligned word load, never touches the bus
    access(1'b0, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 1, 32'h1111_1111);
    // timeout, then ack on the last allowed cycle
    access(1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 0, 32'h0);
    access(1'b0, 1'b1, 1'b0, 32'h0000_0404, 32'h0, TO, 32'hCAFE_F00D);

    // reset in the middle of a bus cycle clears flags and drops bus_req
    mem_rd = 1'b1;
    addr = 32'h0000_0040;
    #1;
    step();
    check("midbus_req", {31'd0, bus_req}, 32'd1);
    do_reset();

    // load acked on second BUS cycle; store acked on first
    access(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 1'b0, 32'h0000_0204, 32'h1234_5678, 1, 32'h0BAD_0BAD);
    access(1'b1, 1'b1, 1'b0, 32'h0000_0208, 32'h8765_4321, 3, 32'h0BAD_0BAD);
    idle_noise(3);

`ifdef DMC_BYTE_ACCESS_EN
    access(1'b0, 1'b1, 1'b1, 32'h0000_0303, 32'h0, 1, 32'hAABB_CCDD);
    access(1'b1, 1'b0, 1'b1, 32'h0000_0301, 32'h0000_0055, 1, 32'h0);
`endif

    for (int t = 0; t < 60; t++) begin
      if (t % 20 == 19) do_reset();
      kind = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      ack_at = (sel == 0) ? 0 : (sel == 1) ? TO : $urandom_range(1, 4);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      access(kind != 0, kind != 1, 1'($urandom), a, $urandom, ack_at, $urandom);
      if ($urandom_range(0, 2) == 0) idle_noise($urandom_range(1, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "simulation time limit");
  end

endmodule

`default_nettype wire
